// File: rtl/ring_osc_meter.sv
// Ring-oscillator meter: gates osc_in rising edges over a clk window.
// Define RING_OSC_METER_CONT_EN for continuous re-measurement mode.
module ring_osc_meter #(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_count,
  output logic             overflow
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int GW =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [SW-1:0] S_LAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST =
    GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_d;

  logic s1;
  logic s2;
  logic s3;
  logic edge_p;

  logic [SW-1:0] settle_cnt;
  logic [GW-1:0] gate_cnt;
  logic          settle_done;
  logic          gate_done;
  logic          hs;

  logic             osc_en_d;
  logic             busy_d;
  logic             valid_d;
  logic [CNT_W-1:0] count_d;
  logic             ovf_d;

  // Three-flop synchronizer; edge pulse taken past the metastable stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_p = s2 & ~s3;

  assign settle_done = (settle_cnt == S_LAST);
  assign gate_done   = (gate_cnt == G_LAST);
  assign hs          = result_valid & result_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      if (settle_done) begin
        settle_cnt <= '0;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end else begin
      settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_cnt <= '0;
    end else if (state == GATE) begin
      if (gate_done) begin
        gate_cnt <= '0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
      end
    end else begin
      gate_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_d = GATE;
        end
      end
      GATE: begin
        if (gate_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (hs) begin
`ifdef RING_OSC_METER_CONT_EN
          state_d = SETTLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    osc_en_d = osc_en;
    busy_d   = busy;
    valid_d  = result_valid;
    count_d  = result_count;
    ovf_d    = overflow;
    unique case (state)
      IDLE: begin
        if (start) begin
          osc_en_d = 1'b1;
          busy_d   = 1'b1;
          count_d  = '0;
          ovf_d    = 1'b0;
        end
      end
      SETTLE: begin
      end
      GATE: begin
        // Saturate rather than wrap so a fast ring never reads slow.
        if (edge_p) begin
          if (&result_count) begin
            ovf_d = 1'b1;
          end else begin
            count_d = result_count + 1'b1;
          end
        end
        if (gate_done) begin
          valid_d = 1'b1;
`ifndef RING_OSC_METER_CONT_EN
          osc_en_d = 1'b0;
`endif
        end
      end
      DONE: begin
        if (hs) begin
          valid_d = 1'b0;
`ifdef RING_OSC_METER_CONT_EN
          count_d = '0;
          ovf_d   = 1'b0;
`else
          busy_d  = 1'b0;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      osc_en       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_count <= '0;
      overflow     <= 1'b0;
    end else begin
      osc_en       <= osc_en_d;
      busy         <= busy_d;
      result_valid <= valid_d;
      result_count <= count_d;
      overflow     <= ovf_d;
    end
  end

endmodule
